// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_en input conditioner.
// State encodings, glitch counter width and a saturating increment helper.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW    = 2'd0,
      S_WAIT_H = 2'd1,
      S_HIGH   = 2'd2,
      S_WAIT_L = 2'd3
   } state_e;

   localparam int GLITCH_CNT_W = 8;

   function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/debounce_en_if.sv
// Signal bundle between a raw input source and the debounce_en conditioner.
// glitch_cnt exists only when DEBOUNCE_GLITCH_CNT_EN is defined.
interface debounce_en_if;
   import debounce_pkg::*;

   logic din;
   logic dout;
   logic en_pulse;
   logic rise;
   logic fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [GLITCH_CNT_W-1:0] glitch_cnt;

   modport master (output din, input dout, en_pulse, rise, fall, glitch_cnt);
   modport slave  (input din, output dout, en_pulse, rise, fall, glitch_cnt);
`else
   modport master (output din, input dout, en_pulse, rise, fall);
   modport slave  (input din, output dout, en_pulse, rise, fall);
`endif

endinterface

// File: rtl/sync_ff.sv
// STAGES-deep flop synchroniser for a single asynchronous bit.
// Synchronous active-high reset clears every stage.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_en.sv
// Debouncer: synchronise din, accept a level after STABLE_CNT stable samples, strobe en/rise/fall.
// Optional glitch counter output enabled by defining DEBOUNCE_GLITCH_CNT_EN.
//
//   state    | meaning
//   S_LOW    | accepted level 0, s agrees
//   S_WAIT_H | s went 1, counting stable high samples
//   S_HIGH   | accepted level 1, s agrees
//   S_WAIT_L | s went 0, counting stable low samples
module debounce_en
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 1000,
   parameter int CNT_W       = 16
) (
   input  logic          clk,
   input  logic          rst,
   debounce_en_if.slave  bus
);

   // cnt_q holds how many samples of the new level were already seen, so the
   // STABLE_CNT-th sample is the one that commits.
   localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(STABLE_CNT - 1);
   localparam bit               ONE_CYCLE = (STABLE_CNT == 1);

   logic             s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             en_q, en_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.din),
      .q   (s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      en_d    = 1'b0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: if (s) begin
            if (ONE_CYCLE) begin
               state_d = S_HIGH;
               dout_d  = 1'b1;
               en_d    = 1'b1;
               rise_d  = 1'b1;
            end else begin
               state_d = S_WAIT_H;
               cnt_d   = CNT_W'(1);
            end
         end
         S_WAIT_H: if (!s) begin
            state_d = S_LOW;
            cnt_d   = '0;
         end else if (cnt_q == ACCEPT_AT) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            dout_d  = 1'b1;
            en_d    = 1'b1;
            rise_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         S_HIGH: if (!s) begin
            if (ONE_CYCLE) begin
               state_d = S_LOW;
               dout_d  = 1'b0;
               en_d    = 1'b1;
               fall_d  = 1'b1;
            end else begin
               state_d = S_WAIT_L;
               cnt_d   = CNT_W'(1);
            end
         end
         S_WAIT_L: if (s) begin
            state_d = S_HIGH;
            cnt_d   = '0;
         end else if (cnt_q == ACCEPT_AT) begin
            state_d = S_LOW;
            cnt_d   = '0;
            dout_d  = 1'b0;
            en_d    = 1'b1;
            fall_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: state_d = S_LOW;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         en_q    <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         en_q    <= en_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic                    glitch_ev;
   logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

   always_comb begin
      glitch_ev = ((state_q == S_WAIT_H) && (state_d == S_LOW)) ||
                  ((state_q == S_WAIT_L) && (state_d == S_HIGH));
      glitch_d  = glitch_ev ? sat_inc(glitch_q) : glitch_q;
   end

   always_ff @(posedge clk) begin
      if (rst) glitch_q <= '0;
      else     glitch_q <= glitch_d;
   end

   assign bus.glitch_cnt = glitch_q;
`endif

   assign bus.dout     = dout_q;
   assign bus.en_pulse = en_q;
   assign bus.rise     = rise_q;
   assign bus.fall     = fall_q;

endmodule
